// File: rtl/deinterleaver_top_if.sv
// deinterleaver_top_if: bit-serial valid/ready streams on both sides of the deinterleaver
interface deinterleaver_top_if;
    logic data_in;
    logic valid_in;
    logic ready_out;
    logic data_out;
    logic valid_out;
    logic ready_in;
    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, data_out, valid_out
    );
    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out
    );
endinterface

// File: rtl/deinterleaver_top.sv
// deinterleaver_top: QPSK WiMAX block deinterleaver; bits are scattered into a
// ping-pong flop bank at their natural position and streamed out in order.
module deinterleaver_top #(
    parameter int NCBPS = 192,
    parameter int D     = 16,
    parameter int AW    = $clog2(NCBPS)
) (
    input logic                clk,
    input logic                resetN,
    deinterleaver_top_if.slave bus
);
    localparam int R  = NCBPS / D;
    localparam int CW = $clog2(R);
    localparam int RW = $clog2(D);

    logic [1:0][NCBPS-1:0] bank_q, bank_d;
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [AW-1:0]         wr_addr;
    logic                  wr_fire, rd_fire, col_wrap, wr_last, rd_last;

    // k = d*col + row, with d a power of two
    always_comb begin
        wr_addr   = (AW'(col_q) << RW) + AW'(row_q);
        wr_fire   = bus.valid_in && !full_q[wr_bank_q];
        rd_fire   = full_q[rd_bank_q] && bus.ready_in;
        col_wrap  = col_q == CW'(R - 1);
        wr_last   = col_wrap && row_q == RW'(D - 1);
        rd_last   = rd_addr_q == AW'(NCBPS - 1);
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        col_d     = col_q;
        row_d     = row_q;
        rd_addr_d = rd_addr_q;
        if (wr_fire) begin
            bank_d[wr_bank_q][wr_addr] = bus.data_in;
            col_d = col_wrap ? '0 : col_q + CW'(1);
            row_d = col_wrap ? row_q + RW'(1) : row_q;
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d = !wr_bank_q;
                col_d = '0;
                row_d = '0;
            end
        end
        // read and write always address opposite banks, so both flag updates can land together
        if (rd_fire) begin
            rd_addr_d = rd_last ? '0 : rd_addr_q + AW'(1);
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d = !rd_bank_q;
            end
        end
    end

    always_comb begin
        bus.ready_out = !full_q[wr_bank_q];
        bus.valid_out = full_q[rd_bank_q];
        bus.data_out  = full_q[rd_bank_q] ? bank_q[rd_bank_q][rd_addr_q] : 1'b0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            rd_addr_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // bank contents are only read under a set full flag, so they need no reset
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end
endmodule
